// File: rtl/iter_alu_pkg.sv
// Shared encodings and sizing for the iterative ALU (MUL is built only with ITER_ALU_MUL_EN).
package iter_alu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int MUL_ITERS      = 8;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRL = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  // Number of RUN steps an operation needs; zero sends the FSM straight to FIN.
  function automatic logic [CNT_W-1:0] iter_count(input op_e op, input logic [2:0] shamt);
    if (op == OP_MUL) begin
`ifdef ITER_ALU_MUL_EN
      return CNT_W'(MUL_ITERS);
`else
      return '0;
`endif
    end
    return CNT_W'(shamt);
  endfunction

endpackage

// File: rtl/iter_alu_step.sv
// One combinational iteration: a 1-bit shift of the accumulator, or one shift-add MUL step
// (multiplicand/multiplier ports exist only with ITER_ALU_MUL_EN).
module iter_alu_step
  import iter_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
`ifdef ITER_ALU_MUL_EN
  input  logic [DATA_WIDTH-1:0] mcand_i,
  input  logic [DATA_WIDTH-1:0] mplier_i,
  output logic [DATA_WIDTH-1:0] mcand_o,
  output logic [DATA_WIDTH-1:0] mplier_o,
`endif
  output logic [DATA_WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
`ifdef ITER_ALU_MUL_EN
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
`endif
    case (op_e'(op_i))
      OP_SLL:  acc_o = {acc_i[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  acc_o = {1'b0, acc_i[DATA_WIDTH-1:1]};
      OP_SRA:  acc_o = {acc_i[DATA_WIDTH-1], acc_i[DATA_WIDTH-1:1]};
      default: begin
`ifdef ITER_ALU_MUL_EN
        // Multiplier consumed LSB first; the sum wraps to the low byte.
        if (mplier_i[0]) acc_o = acc_i + mcand_i;
`endif
      end
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative MUL/SLL/SRL/SRA unit: one bit per clock, DONE pulses for one cycle in FIN.
// MUL datapath exists only when ITER_ALU_MUL_EN is defined; otherwise OP=00 returns 0 at once.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [1:0]            OP,
  input  logic [DATA_WIDTH-1:0] DATA1,
  input  logic [DATA_WIDTH-1:0] DATA2,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  BUSY,
  output logic                  DONE
);

  state_e                state_q;
  op_e                   op_q;
  op_e                   op_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      n_d;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_d;
  logic                  busy_q;
  logic                  done_q;

  assign op_d = op_e'(OP);
  assign n_d  = iter_count(op_d, DATA2[2:0]);

`ifdef ITER_ALU_MUL_EN
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
`else
  logic unused_data2;
  assign unused_data2 = ^DATA2[DATA_WIDTH-1:3];
`endif

  iter_alu_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .op_i     (op_q),
    .acc_i    (acc_q),
`ifdef ITER_ALU_MUL_EN
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d),
`endif
    .acc_o    (acc_d)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ITER_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_FIN: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= ST_IDLE;
          if (START) begin
            op_q  <= op_d;
            cnt_q <= n_d;
            // MUL accumulates from zero; shifts work in place on operand A.
            acc_q <= (op_d == OP_MUL) ? '0 : DATA1;
`ifdef ITER_ALU_MUL_EN
            mcand_q  <= DATA1;
            mplier_q <= DATA2;
`endif
            if (n_d == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
`ifdef ITER_ALU_MUL_EN
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
`endif
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign RESULT = acc_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, operand/result width; only 8 is required to be supported.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RESET  input  1  asynchronous, active-high reset.
REQ-004 Port: START  input  1  request; sampled on rising CLK.
REQ-005 Port: OP  input  2  00 MUL, 01 SLL, 10 SRL, 11 SRA.
REQ-006 Port: DATA1  input  8  operand A (register file REGOUT1).
REQ-007 Port: DATA2  input  8  operand B / shift amount (register file REGOUT2).
REQ-008 Port: RESULT  output  8  result for register file WRITEDATA.
REQ-009 Port: BUSY  output  1  high while in RUN.
REQ-010 Port: DONE  output  1  one-cycle pulse; drives register file WRITEENABLE.

Function
REQ-011 FSM states SHALL be IDLE, RUN, FIN; encoding from shared package.
REQ-012 START SHALL be accepted only in IDLE or FIN; DATA1, DATA2 and OP are latched on the accepting edge (edge k).
REQ-013 START in RUN SHALL be ignored, with no change to the latched operands.
REQ-014 Iteration count N: MUL = 8; shifts = DATA2[2:0]; DATA2[7:3] are ignored for shifts.
REQ-015 If N=0 at edge k, the state SHALL go to FIN; otherwise it goes to RUN with counter = N.
REQ-016 RUN edges k+1..k+N: one step each, counter decrements; at edge k+N the state goes to FIN.
REQ-017 MUL step: shift-add, one multiplier bit per edge, LSB first; RESULT = (DATA1*DATA2) mod 256 (unsigned, low byte).
REQ-018 Shift steps: one bit per edge; SLL/SRL zero-fill; SRA replicates bit 7.
REQ-019 In FIN, DONE SHALL be 1 for exactly one cycle; the state then returns to IDLE, or to RUN/FIN if START is accepted in FIN.
REQ-020 RESULT SHALL be valid in FIN and held unchanged until the next accepted START.
REQ-021 RESULT during RUN is unspecified; consumers use it only when DONE=1.
REQ-022 BUSY SHALL be 1 exactly in RUN; BUSY and DONE are never both 1.
REQ-023 N=0 shift: RESULT = DATA1, DONE in the cycle after edge k.

Reset
REQ-024 RESET=1 SHALL immediately force state IDLE, RESULT 8'h00, BUSY 0, DONE 0, counter 0, regardless of CLK.
REQ-025 Reset mid-operation SHALL abandon the operation; no DONE is produced for it.
REQ-026 START is ignored while RESET=1; the first acceptance is on the first rising edge with RESET=0.

Configuration
REQ-027 Macro ITER_ALU_MUL_EN defined: MUL implemented per REQ-017.
REQ-028 ITER_ALU_MUL_EN undefined: no multiplier datapath is synthesised; OP=00 uses N=0, RESULT 8'h00, DONE next cycle; shifts unchanged.

Structure
REQ-029 Shared package iter_alu_pkg SHALL hold: OP encodings, FSM state encodings, DATA_WIDTH default, MUL iteration count (8).
REQ-030 Sub-module iter_alu_step: combinational single-step datapath (add/shift) instantiated by iter_alu; FSM and counter stay in iter_alu.

Verification
REQ-031 MUL 6*15: START at edge k, OP=00, DATA1=6, DATA2=15 -> BUSY edges k..k+7, DONE after edge k+8, RESULT 8'h5A.
REQ-032 MUL overflow 28*15 -> RESULT 8'hA4; SLL 95 by 3 -> 8'hF8 with DONE after edge k+3.
REQ-033 SRL 8'h80 by 2 -> 8'h20; SRA 8'h80 by 2 -> 8'hE0; SLL 8'h5A by 0 -> 8'h5A, DONE after edge k.
REQ-034 START with OP=01 asserted during a running MUL -> ignored; MUL completes with correct RESULT, single DONE pulse.
REQ-035 RESET pulse mid-MUL (edge k+4) -> BUSY, DONE, RESULT immediately 0; no DONE afterwards; a new MUL 3*3 after reset -> 8'h09.
REQ-036 Back-to-back: START held high in FIN -> new operation accepted; DONE pulses once per operation. Build without ITER_ALU_MUL_EN: OP=00 -> RESULT 8'h00 after 1 cycle.
